system_ecc_stream_decoder: RTL and testbench
============================================

Name: system_ecc_stream_decoder

Overview:
- Pipelined, flow-controlled SECDED decoder for the 13-bit system ECC codeword produced by system_ecc_encoder.
- Sits on the memory read-return path, between the ECC-protected storage and the consumer.
- Uses valid/ready handshakes on both sides and has two register stages.
- Classifies every word, corrects single-bit errors, flags double-bit errors, and keeps saturating error statistics.

Parameters:
- DATA_WIDTH, 8, data bits per word. Only 8 is supported; the codeword is DATA_WIDTH+5 = 13 bits.
- COUNT_WIDTH, 16, width of each error counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  codeword_in is valid.
- in_ready  output  1  decoder can accept a word this cycle.
- codeword_in  input  13  bit 12 = system parity; bits [11:0] = {d7 d6 d5 d4 p3 d3 d2 d1 p2 d0 p1 p0}.
- out_valid  output  1  output word and status are valid.
- out_ready  input  1  consumer accepts the output word.
- data_out  output  8  decoded data (corrected when correctable).
- status_out  output  2  00 clean, 01 corrected, 10 uncorrectable, 11 unused.
- syndrome_out  output  4  Hamming syndrome of this word.
- corr_count  output  COUNT_WIDTH  saturating count of accepted corrected words.
- uncorr_count  output  COUNT_WIDTH  saturating count of accepted uncorrectable words.
- uncorr_sticky  output  1  set by any accepted uncorrectable word.
- clear_stats  input  1  synchronous clear of both counters and the sticky flag.

Behaviour:
- Reset (asynchronous, rst_n low): every register clears. out_valid=0, data_out=0, status_out=0, syndrome_out=0, counters=0, uncorr_sticky=0. A word in flight is discarded; no counter updates for it.
- Syndrome equations (cw = codeword):
  - s0 = cw0^cw2^cw4^cw6^cw8^cw10
  - s1 = cw1^cw2^cw5^cw6^cw9^cw10
  - s2 = cw3^cw4^cw5^cw6^cw11
  - s3 = cw7^cw8^cw9^cw10^cw11
  - syndrome = {s3,s2,s1,s0}; perr = ^cw[12:0].
- Classification:
  - syndrome=0, perr=0: clean.
  - syndrome=0, perr=1: corrected (parity bit 12 in error; data unaffected).
  - syndrome in 1..12, perr=1: corrected; flip bit (syndrome-1) of cw[11:0].
  - syndrome non-zero, perr=0: uncorrectable.
  - syndrome in 13..15, perr=1: uncorrectable.
  - When uncorrectable, data is the uncorrected extraction.
- Data extraction: {cw11,cw10,cw9,cw8,cw6,cw5,cw4,cw2}, taken after correction.
- Pipeline:
  - Stage 1 registers the codeword, syndrome and perr.
  - Stage 2 registers data_out, status_out and syndrome_out, and drives out_valid.
  - Latency is 2 cycles from input handshake to out_valid with out_ready held high.
  - Throughput is 1 word per cycle.
- Flow control:
  - advance = !out_valid | out_ready; in_ready = advance (combinational from out_ready).
  - When advance is 0, both stages hold; outputs stay stable while out_valid=1 and out_ready=0.
  - The stage-1 valid bit is loaded with in_valid&in_ready when advance=1.
  - Bubbles propagate; no bubble collapsing is required.
- Statistics:
  - Counters increment only on an output handshake (out_valid&out_ready) with the matching status; each word is counted once.
  - Counters saturate at 2^COUNT_WIDTH-1.
  - clear_stats has priority over a same-cycle increment: the result is 0 and the sticky flag is 0.
  - uncorr_sticky is set on an accepted uncorrectable word and held until clear_stats or reset.

Test Plan:
- Clean word: codeword_in=13'h0A27 (data A5), out_ready=1 -> 2 cycles later out_valid=1, data_out=A5, status=00, syndrome=0, counters unchanged.
- Single data-bit error: 13'h0A23 (bit 2 flipped) -> data_out=A5, status=01, syndrome=3, corr_count=1. Also 13'h1A27 (bit 12 flipped) -> data_out=A5, status=01, syndrome=0, corr_count=2.
- Double error: 13'h0A33 (bits 2 and 4 flipped) -> status=10, syndrome=6, uncorr_count=1, uncorr_sticky=1.
- Backpressure: stream 3 words back-to-back, hold out_ready=0 for 3 cycles after the first out_valid -> in_ready=0, data_out/status held stable. Release -> all 3 words emerge in order with no loss or duplication.
- Saturation and clear: COUNT_WIDTH=2, 5 corrected words -> corr_count stays 3. Assert clear_stats in the same cycle as a 6th corrected handshake -> corr_count=0.
- Reset mid-stream: deassert rst_n while 2 words are in flight -> out_valid=0 immediately, counters=0. After release, the first new word decodes normally with 2-cycle latency.

Source files
------------

// File: rtl/system_ecc_stream_decoder.sv
// Two-stage valid/ready SECDED decoder for the 13-bit system ECC codeword.
// Corrects single-bit errors, flags double-bit errors, and keeps saturating error statistics.
module system_ecc_stream_decoder #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH+4:0]  codeword_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic [1:0]             status_out,
    output logic [3:0]             syndrome_out,
    output logic [COUNT_WIDTH-1:0] corr_count,
    output logic [COUNT_WIDTH-1:0] uncorr_count,
    output logic                   uncorr_sticky,
    input  logic                   clear_stats
);
    localparam logic [1:0] ST_CLEAN  = 2'b00;
    localparam logic [1:0] ST_CORR   = 2'b01;
    localparam logic [1:0] ST_UNCORR = 2'b10;
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic        advance;
    logic [3:0]  syn_in;
    logic        perr_in;

    logic        s1_valid;
    logic [11:0] s1_cw;
    logic [3:0]  s1_syn;
    logic        s1_perr;

    logic [11:0] cw_fix;
    logic [1:0]  status_nxt;
    logic [7:0]  data_nxt;
    logic        out_fire;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        syn_in[0] = codeword_in[0] ^ codeword_in[2] ^ codeword_in[4] ^ codeword_in[6]
                  ^ codeword_in[8] ^ codeword_in[10];
        syn_in[1] = codeword_in[1] ^ codeword_in[2] ^ codeword_in[5] ^ codeword_in[6]
                  ^ codeword_in[9] ^ codeword_in[10];
        syn_in[2] = codeword_in[3] ^ codeword_in[4] ^ codeword_in[5] ^ codeword_in[6]
                  ^ codeword_in[11];
        syn_in[3] = codeword_in[7] ^ codeword_in[8] ^ codeword_in[9] ^ codeword_in[10]
                  ^ codeword_in[11];
        perr_in   = ^codeword_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_cw    <= '0;
            s1_syn   <= '0;
            s1_perr  <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid && in_ready;
            if (in_valid) begin
                s1_cw   <= codeword_in[11:0];
                s1_syn  <= syn_in;
                s1_perr <= perr_in;
            end
        end
    end

    // Syndrome 1..12 with odd overall parity points at cw bit (syndrome-1);
    // syndrome 0 with odd parity means only the parity bit itself flipped.
    always_comb begin
        cw_fix     = s1_cw;
        status_nxt = ST_CLEAN;
        if (s1_syn == 4'd0) begin
            status_nxt = s1_perr ? ST_CORR : ST_CLEAN;
        end else if (s1_perr && (s1_syn <= 4'd12)) begin
            status_nxt = ST_CORR;
            for (int i = 0; i < 12; i++) begin
                if (s1_syn == 4'(i + 1)) cw_fix[i] = ~s1_cw[i];
            end
        end else begin
            status_nxt = ST_UNCORR;
        end
        data_nxt = {cw_fix[11], cw_fix[10], cw_fix[9], cw_fix[8],
                    cw_fix[6], cw_fix[5], cw_fix[4], cw_fix[2]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            data_out     <= '0;
            status_out   <= ST_CLEAN;
            syndrome_out <= '0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                data_out     <= data_nxt;
                status_out   <= status_nxt;
                syndrome_out <= s1_syn;
            end
        end
    end

    // Statistics count only accepted words so a stalled word is never counted twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_count    <= '0;
            uncorr_count  <= '0;
            uncorr_sticky <= 1'b0;
        end else if (clear_stats) begin
            corr_count    <= '0;
            uncorr_count  <= '0;
            uncorr_sticky <= 1'b0;
        end else if (out_fire) begin
            if (status_out == ST_CORR && corr_count != CNT_MAX)
                corr_count <= corr_count + COUNT_WIDTH'(1);
            if (status_out == ST_UNCORR) begin
                uncorr_sticky <= 1'b1;
                if (uncorr_count != CNT_MAX)
                    uncorr_count <= uncorr_count + COUNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_system_ecc_stream_decoder.sv
// Directed, table-driven bench for system_ecc_stream_decoder; a second instance with
// 2-bit counters exercises saturation.
module tb_system_ecc_stream_decoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready2;
    logic [12:0] codeword_in;
    logic        out_valid;
    logic        out_valid2;
    logic        out_ready;
    logic [7:0]  data_out;
    logic [7:0]  data_out2;
    logic [1:0]  status_out;
    logic [1:0]  status_out2;
    logic [3:0]  syndrome_out;
    logic [3:0]  syndrome_out2;
    logic [15:0] corr_count;
    logic [15:0] uncorr_count;
    logic [1:0]  corr_count2;
    logic [1:0]  uncorr_count2;
    logic        uncorr_sticky;
    logic        uncorr_sticky2;
    logic        clear_stats;

    always #5 clk = ~clk;

    system_ecc_stream_decoder #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .codeword_in(codeword_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .status_out(status_out), .syndrome_out(syndrome_out),
        .corr_count(corr_count), .uncorr_count(uncorr_count),
        .uncorr_sticky(uncorr_sticky), .clear_stats(clear_stats)
    );

    system_ecc_stream_decoder #(.DATA_WIDTH(8), .COUNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .codeword_in(codeword_in), .out_valid(out_valid2), .out_ready(out_ready),
        .data_out(data_out2), .status_out(status_out2), .syndrome_out(syndrome_out2),
        .corr_count(corr_count2), .uncorr_count(uncorr_count2),
        .uncorr_sticky(uncorr_sticky2), .clear_stats(clear_stats)
    );

    typedef struct {
        logic [12:0] cw;
        logic [7:0]  data;
        logic [1:0]  st;
        logic [3:0]  syn;
    } vec_t;

    vec_t vecs[11];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_corr, exp_uncorr, exp_corr2, exp_uncorr2;
    logic exp_sticky;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_accept(input logic [1:0] st, input logic clr);
        if (clr) begin
            exp_corr = 0; exp_uncorr = 0; exp_corr2 = 0; exp_uncorr2 = 0;
            exp_sticky = 1'b0;
        end else if (st == 2'b01) begin
            exp_corr  = (exp_corr == 65535) ? 65535 : exp_corr + 1;
            exp_corr2 = (exp_corr2 == 3) ? 3 : exp_corr2 + 1;
        end else if (st == 2'b10) begin
            exp_uncorr  = (exp_uncorr == 65535) ? 65535 : exp_uncorr + 1;
            exp_uncorr2 = (exp_uncorr2 == 3) ? 3 : exp_uncorr2 + 1;
            exp_sticky  = 1'b1;
        end
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_corr"}, corr_count, exp_corr);
        chk({tag, "_uncorr"}, uncorr_count, exp_uncorr);
        chk({tag, "_sticky"}, uncorr_sticky, exp_sticky);
        chk({tag, "_corr_sat"}, corr_count2, exp_corr2);
        chk({tag, "_uncorr_sat"}, uncorr_count2, exp_uncorr2);
        chk({tag, "_sticky_sat"}, uncorr_sticky2, exp_sticky);
    endtask

    // One word through an idle pipe; optional clear_stats on its output handshake.
    task automatic send_one(input vec_t v, input logic clr);
        int cyc;
        in_valid    = 1'b1;
        codeword_in = v.cw;
        out_ready   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 6) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, 1);
        chk("out_valid", out_valid, 1);
        chk("data", data_out, v.data);
        chk("status", status_out, v.st);
        chk("syndrome", syndrome_out, v.syn);
        clear_stats = clr;
        @(posedge clk); #1;
        clear_stats = 1'b0;
        model_accept(v.st, clr);
        chk("drained", out_valid, 0);
        check_stats("stats");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] got[4];
        int         n_got;

        vecs[0]  = '{13'h0A27, 8'hA5, 2'b00, 4'd0};
        vecs[1]  = '{13'h0A23, 8'hA5, 2'b01, 4'd3};
        vecs[2]  = '{13'h1A27, 8'hA5, 2'b01, 4'd0};
        vecs[3]  = '{13'h0A33, 8'hA6, 2'b10, 4'd6};
        vecs[4]  = '{13'h0227, 8'hA5, 2'b01, 4'd12};
        vecs[5]  = '{13'h0A26, 8'hA5, 2'b01, 4'd1};
        vecs[6]  = '{13'h0AAE, 8'hA5, 2'b10, 4'd13};
        vecs[7]  = '{13'h0000, 8'h00, 2'b00, 4'd0};
        vecs[8]  = '{13'h0F77, 8'hFF, 2'b00, 4'd0};
        vecs[9]  = '{13'h0F57, 8'hFF, 2'b01, 4'd6};
        vecs[10] = '{13'h0803, 8'h80, 2'b10, 4'd15};

        exp_corr = 0; exp_uncorr = 0; exp_corr2 = 0; exp_uncorr2 = 0;
        exp_sticky = 1'b0;

        rst_n = 1'b0; in_valid = 1'b0; codeword_in = '0; out_ready = 1'b0;
        clear_stats = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_status", status_out, 0);
        chk("rst_syndrome", syndrome_out, 0);
        chk("rst_in_ready", in_ready, 1);
        check_stats("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) send_one(vecs[i], 1'b0);

        // Backpressure: A accepted, B accepted, C waits while the consumer stalls.
        in_valid = 1'b1; codeword_in = vecs[0].cw; out_ready = 1'b1;
        @(posedge clk); #1;
        codeword_in = vecs[8].cw;
        @(posedge clk); #1;
        chk("bp_first_valid", out_valid, 1);
        out_ready   = 1'b0;
        codeword_in = vecs[7].cw;
        #1;
        chk("bp_in_ready_low", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", data_out, 8'hA5);
            chk("bp_hold_status", status_out, 2'b00);
            chk("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        n_got = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) begin
                if (n_got < 4) got[n_got] = data_out;
                n_got++;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        chk("bp_word_count", n_got, 3);
        chk("bp_word0", got[0], 8'hA5);
        chk("bp_word1", got[1], 8'hFF);
        chk("bp_word2", got[2], 8'h00);
        check_stats("bp_stats");

        // Saturation and clear priority.
        clear_stats = 1'b1;
        @(posedge clk); #1;
        clear_stats = 1'b0;
        model_accept(2'b00, 1'b1);
        check_stats("clear_idle");
        for (int k = 0; k < 5; k++) send_one(vecs[1], 1'b0);
        chk("sat_corr_at_max", corr_count2, 3);
        send_one(vecs[3], 1'b0);
        chk("sat_sticky_set", uncorr_sticky2, 1);
        send_one(vecs[2], 1'b1);
        chk("clear_wins_corr", corr_count2, 0);

        // Reset with two words in flight.
        send_one(vecs[9], 1'b0);
        send_one(vecs[3], 1'b0);
        in_valid = 1'b1; codeword_in = vecs[1].cw; out_ready = 1'b1;
        @(posedge clk); #1;
        codeword_in = vecs[3].cw;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_valid_before_rst", out_valid, 1);
        rst_n = 1'b0;
        #1;
        model_accept(2'b00, 1'b1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_data", data_out, 0);
        check_stats("mid_rst");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("no_ghost_word", out_valid, 0);
        check_stats("after_rst");
        send_one(vecs[0], 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
